// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants.
//   reg_idx_t    : 3-bit general-purpose register index
//   nzp_t        : packed condition codes {n, z, p}
//   CC_RESET_VAL : NZP value after reset (Z set)
//   NUM_GPR      : number of general-purpose registers
package lc3_pkg;

  typedef logic [2:0] reg_idx_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam logic [2:0]  CC_RESET_VAL = 3'b010;
  localparam int unsigned NUM_GPR      = 8;

endpackage

// File: rtl/cc_gen.sv
// Condition-code generator: classifies a bus value as negative, zero or positive.
// Purely combinational; also intended for reuse by the PSR logic.
//   bus_i : N-bit value to classify
//   nzp_o : one-hot {n, z, p}
module cc_gen
  import lc3_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] bus_i,
  output nzp_t         nzp_o
);

  logic is_zero;

  // Zero detect spans the full width; sign is always the MSB.
  assign is_zero = (bus_i == '0);

  always_comb begin
    nzp_o   = '0;
    nzp_o.n = bus_i[N-1];
    nzp_o.z = is_zero;
    nzp_o.p = ~bus_i[N-1] & ~is_zero;
  end

endmodule

// File: rtl/mux_8to1.sv
// N-bit 8:1 multiplexer used for the register-file read ports.
//   sel_i        : 3-bit select
//   d0_i .. d7_i : N-bit data inputs
//   y_o          : selected input
module Mux_8to1 #(
  parameter int unsigned N = 16
) (
  input  logic [2:0]   sel_i,
  input  logic [N-1:0] d0_i,
  input  logic [N-1:0] d1_i,
  input  logic [N-1:0] d2_i,
  input  logic [N-1:0] d3_i,
  input  logic [N-1:0] d4_i,
  input  logic [N-1:0] d5_i,
  input  logic [N-1:0] d6_i,
  input  logic [N-1:0] d7_i,
  output logic [N-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      3'd0: y_o = d0_i;
      3'd1: y_o = d1_i;
      3'd2: y_o = d2_i;
      3'd3: y_o = d3_i;
      3'd4: y_o = d4_i;
      3'd5: y_o = d5_i;
      3'd6: y_o = d6_i;
      3'd7: y_o = d7_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/reg_file_cc.sv
// LC-3 general-purpose register file with condition codes and branch enable.
//   Clk, Reset_n         : clock, asynchronous active-low reset
//   Bus                  : processor bus (write data for R[DR], NZP source)
//   DR, LD_REG           : destination index and write strobe
//   LD_CC                : load NZP from Bus
//   LD_BEN, IR_NZP       : load BEN = |(IR_NZP & NZP) using pre-edge NZP
//   SR1, SR2             : combinational read selects
//   R0..R7               : registered register contents
//   SR1_Out, SR2_Out     : R[SR1], R[SR2] (no write-through bypass)
//   NZP, BEN             : registered flags
module reg_file_cc
  import lc3_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter logic [2:0]  CC_RESET = CC_RESET_VAL
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [N-1:0] Bus,
  input  reg_idx_t     DR,
  input  logic         LD_REG,
  input  logic         LD_CC,
  input  logic         LD_BEN,
  input  logic [2:0]   IR_NZP,
  input  reg_idx_t     SR1,
  input  reg_idx_t     SR2,
  output logic [N-1:0] R0,
  output logic [N-1:0] R1,
  output logic [N-1:0] R2,
  output logic [N-1:0] R3,
  output logic [N-1:0] R4,
  output logic [N-1:0] R5,
  output logic [N-1:0] R6,
  output logic [N-1:0] R7,
  output logic [N-1:0] SR1_Out,
  output logic [N-1:0] SR2_Out,
  output logic [2:0]   NZP,
  output logic         BEN
);

  logic [N-1:0] gpr_q [NUM_GPR];
  nzp_t         nzp_q, nzp_d;
  logic         ben_q, ben_d;

  cc_gen #(
    .N (N)
  ) u_cc_gen (
    .bus_i (Bus),
    .nzp_o (nzp_d)
  );

  // Old flags feed BEN so a same-cycle LD_CC does not affect it.
  assign ben_d = |(IR_NZP & nzp_q);

  // Selects and IR_NZP only matter under their strobes, so X on them never reaches state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gpr_q <= '{default: '0};
      nzp_q <= nzp_t'(CC_RESET);
      ben_q <= 1'b0;
    end else begin
      if (LD_REG) gpr_q[DR] <= Bus;
      if (LD_CC)  nzp_q     <= nzp_d;
      if (LD_BEN) ben_q     <= ben_d;
    end
  end

  assign R0  = gpr_q[0];
  assign R1  = gpr_q[1];
  assign R2  = gpr_q[2];
  assign R3  = gpr_q[3];
  assign R4  = gpr_q[4];
  assign R5  = gpr_q[5];
  assign R6  = gpr_q[6];
  assign R7  = gpr_q[7];
  assign NZP = nzp_q;
  assign BEN = ben_q;

  Mux_8to1 #(
    .N (N)
  ) u_sr1_mux (
    .sel_i (SR1),
    .d0_i  (gpr_q[0]),
    .d1_i  (gpr_q[1]),
    .d2_i  (gpr_q[2]),
    .d3_i  (gpr_q[3]),
    .d4_i  (gpr_q[4]),
    .d5_i  (gpr_q[5]),
    .d6_i  (gpr_q[6]),
    .d7_i  (gpr_q[7]),
    .y_o   (SR1_Out)
  );

  Mux_8to1 #(
    .N (N)
  ) u_sr2_mux (
    .sel_i (SR2),
    .d0_i  (gpr_q[0]),
    .d1_i  (gpr_q[1]),
    .d2_i  (gpr_q[2]),
    .d3_i  (gpr_q[3]),
    .d4_i  (gpr_q[4]),
    .d5_i  (gpr_q[5]),
    .d6_i  (gpr_q[6]),
    .d7_i  (gpr_q[7]),
    .y_o   (SR2_Out)
  );

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed self-checking bench for reg_file_cc.
module tb_reg_file_cc;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Bus;
  logic [2:0]  DR;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic [2:0]  IR_NZP;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [15:0] SR1_Out;
  logic [15:0] SR2_Out;
  logic [2:0]  NZP;
  logic        BEN;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_r [8];
  logic [15:0] obs_r [8];

  reg_file_cc #(
    .N        (16),
    .CC_RESET (3'b010)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Bus     (Bus),
    .DR      (DR),
    .LD_REG  (LD_REG),
    .LD_CC   (LD_CC),
    .LD_BEN  (LD_BEN),
    .IR_NZP  (IR_NZP),
    .SR1     (SR1),
    .SR2     (SR2),
    .R0      (R0),
    .R1      (R1),
    .R2      (R2),
    .R3      (R3),
    .R4      (R4),
    .R5      (R5),
    .R6      (R6),
    .R7      (R7),
    .SR1_Out (SR1_Out),
    .SR2_Out (SR2_Out),
    .NZP     (NZP),
    .BEN     (BEN)
  );

  assign obs_r[0] = R0;
  assign obs_r[1] = R1;
  assign obs_r[2] = R2;
  assign obs_r[3] = R3;
  assign obs_r[4] = R4;
  assign obs_r[5] = R5;
  assign obs_r[6] = R6;
  assign obs_r[7] = R7;

  always #5 Clk = ~Clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    LD_BEN = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle();
    Bus = 16'h0000; DR = 3'd0; SR1 = 3'd0; SR2 = 3'd0; IR_NZP = 3'b000;
    repeat (2) tick();
    Reset_n = 1'b1;
    // Dirty the state: BEN from reset NZP=010, NZP->100, R2=FFFF.
    LD_REG = 1'b1; DR = 3'd2; Bus = 16'hFFFF; LD_CC = 1'b1; LD_BEN = 1'b1; IR_NZP = 3'b010;
    tick();
    idle();
    vectors++;
    if (R2 !== 16'hFFFF) begin
      miscompares++; $display("FAIL pre_reset_R2: got %h want %h", R2, 16'hFFFF);
    end
    vectors++;
    if (NZP !== 3'b100) begin
      miscompares++; $display("FAIL pre_reset_NZP: got %b want %b", NZP, 3'b100);
    end
    vectors++;
    if (BEN !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_BEN: got %b want %b", BEN, 1'b1);
    end
    // Assert reset mid-cycle with strobes active; effect must be immediate.
    #3;
    Reset_n = 1'b0;
    LD_REG = 1'b1; DR = 3'd2; Bus = 16'hFFFF; LD_CC = 1'b1; LD_BEN = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_r[i] = 16'h0000;
      vectors++;
      if (obs_r[i] !== exp_r[i]) begin
        miscompares++; $display("FAIL async_reset_R%0d: got %h want %h", i, obs_r[i], exp_r[i]);
      end
    end
    vectors++;
    if (NZP !== 3'b010) begin
      miscompares++; $display("FAIL async_reset_NZP: got %b want %b", NZP, 3'b010);
    end
    vectors++;
    if (BEN !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_BEN: got %b want %b", BEN, 1'b0);
    end
    // Reset overrides strobes across an edge too.
    tick();
    vectors++;
    if (R2 !== 16'h0000) begin
      miscompares++; $display("FAIL reset_edge_R2: got %h want %h", R2, 16'h0000);
    end
    vectors++;
    if (NZP !== 3'b010) begin
      miscompares++; $display("FAIL reset_edge_NZP: got %b want %b", NZP, 3'b010);
    end
    idle();
    #2;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    LD_REG = 1'b1; DR = 3'd5; Bus = 16'h1234;
    tick();
    idle();
    exp_r[5] = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs_r[i] !== exp_r[i]) begin
        miscompares++; $display("FAIL write_R%0d: got %h want %h", i, obs_r[i], exp_r[i]);
      end
    end
    SR1 = 3'd5; SR2 = 3'd5;
    #1;
    vectors++;
    if (SR1_Out !== 16'h1234) begin
      miscompares++; $display("FAIL read_SR1_same: got %h want %h", SR1_Out, 16'h1234);
    end
    vectors++;
    if (SR2_Out !== 16'h1234) begin
      miscompares++; $display("FAIL read_SR2_same: got %h want %h", SR2_Out, 16'h1234);
    end
  endtask

  task automatic test_no_bypass();
    LD_REG = 1'b1; DR = 3'd3; Bus = 16'h0001;
    tick();
    exp_r[3] = 16'h0001;
    LD_REG = 1'b1; DR = 3'd3; Bus = 16'h00FF; SR1 = 3'd3; SR2 = 3'd5;
    #1;
    vectors++;
    if (SR1_Out !== 16'h0001) begin
      miscompares++; $display("FAIL no_bypass_before: got %h want %h", SR1_Out, 16'h0001);
    end
    tick();
    idle();
    exp_r[3] = 16'h00FF;
    vectors++;
    if (SR1_Out !== 16'h00FF) begin
      miscompares++; $display("FAIL no_bypass_after: got %h want %h", SR1_Out, 16'h00FF);
    end
    vectors++;
    if (R3 !== 16'h00FF) begin
      miscompares++; $display("FAIL no_bypass_R3: got %h want %h", R3, 16'h00FF);
    end
  endtask

  task automatic test_cc();
    logic [15:0] bus_v [5] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h0001};
    logic [2:0]  nzp_v [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b001};
    DR = 3'd6;
    for (int i = 0; i < 5; i++) begin
      LD_CC = 1'b1; Bus = bus_v[i];
      tick();
      vectors++;
      if (NZP !== nzp_v[i]) begin
        miscompares++;
        $display("FAIL cc_%h: got %b want %b", bus_v[i], NZP, nzp_v[i]);
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs_r[i] !== exp_r[i]) begin
        miscompares++; $display("FAIL cc_hold_R%0d: got %h want %h", i, obs_r[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_ben();
    LD_CC = 1'b1; Bus = 16'h0000;
    tick();
    vectors++;
    if (NZP !== 3'b010) begin
      miscompares++; $display("FAIL ben_setup_NZP: got %b want %b", NZP, 3'b010);
    end
    // BEN must see the old Z flag, not the N about to be loaded.
    LD_CC = 1'b1; Bus = 16'h8000; LD_BEN = 1'b1; IR_NZP = 3'b010;
    tick();
    vectors++;
    if (BEN !== 1'b1) begin
      miscompares++; $display("FAIL ben_old_flags: got %b want %b", BEN, 1'b1);
    end
    vectors++;
    if (NZP !== 3'b100) begin
      miscompares++; $display("FAIL ben_new_NZP: got %b want %b", NZP, 3'b100);
    end
    LD_CC = 1'b0; LD_BEN = 1'b1; IR_NZP = 3'b010;
    tick();
    vectors++;
    if (BEN !== 1'b0) begin
      miscompares++; $display("FAIL ben_z_mask_on_n: got %b want %b", BEN, 1'b0);
    end
    IR_NZP = 3'b100;
    tick();
    vectors++;
    if (BEN !== 1'b1) begin
      miscompares++; $display("FAIL ben_n_mask: got %b want %b", BEN, 1'b1);
    end
    LD_BEN = 1'b0; IR_NZP = 3'b000;
    tick();
    vectors++;
    if (BEN !== 1'b1) begin
      miscompares++; $display("FAIL ben_hold: got %b want %b", BEN, 1'b1);
    end
    LD_BEN = 1'b1; IR_NZP = 3'b011;
    tick();
    idle();
    vectors++;
    if (BEN !== 1'b0) begin
      miscompares++; $display("FAIL ben_zp_mask: got %b want %b", BEN, 1'b0);
    end
  endtask

  task automatic test_all_regs();
    for (int i = 0; i < 8; i++) begin
      LD_REG = 1'b1; DR = 3'(i); Bus = 16'h1000 * 16'(i + 1) + 16'(i);
      exp_r[i] = Bus;
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs_r[i] !== exp_r[i]) begin
        miscompares++; $display("FAIL all_R%0d: got %h want %h", i, obs_r[i], exp_r[i]);
      end
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      vectors++;
      if (SR1_Out !== exp_r[i]) begin
        miscompares++; $display("FAIL read_SR1_%0d: got %h want %h", i, SR1_Out, exp_r[i]);
      end
      vectors++;
      if (SR2_Out !== exp_r[7 - i]) begin
        miscompares++; $display("FAIL read_SR2_%0d: got %h want %h", 7 - i, SR2_Out, exp_r[7 - i]);
      end
    end
  endtask

  task automatic test_combined();
    // NZP is 100 and R7 is nonzero going in, so both updates are visible.
    LD_REG = 1'b1; DR = 3'd7; LD_CC = 1'b1; Bus = 16'h0000;
    tick();
    idle();
    exp_r[7] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs_r[i] !== exp_r[i]) begin
        miscompares++; $display("FAIL combo_R%0d: got %h want %h", i, obs_r[i], exp_r[i]);
      end
    end
    vectors++;
    if (NZP !== 3'b010) begin
      miscompares++; $display("FAIL combo_NZP: got %b want %b", NZP, 3'b010);
    end
    // All three strobes together from one bus value.
    LD_REG = 1'b1; DR = 3'd0; LD_CC = 1'b1; LD_BEN = 1'b1; IR_NZP = 3'b010; Bus = 16'hFFFF;
    tick();
    idle();
    exp_r[0] = 16'hFFFF;
    vectors++;
    if (R0 !== 16'hFFFF) begin
      miscompares++; $display("FAIL combo3_R0: got %h want %h", R0, 16'hFFFF);
    end
    vectors++;
    if (NZP !== 3'b100) begin
      miscompares++; $display("FAIL combo3_NZP: got %b want %b", NZP, 3'b100);
    end
    vectors++;
    if (BEN !== 1'b1) begin
      miscompares++; $display("FAIL combo3_BEN: got %b want %b", BEN, 1'b1);
    end
    vectors++;
    if (R1 !== exp_r[1]) begin
      miscompares++; $display("FAIL combo3_R1: got %h want %h", R1, exp_r[1]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_bypass();
    test_cc();
    test_ben();
    test_all_regs();
    test_combined();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_cc.md
Name: reg_file_cc

Overview:
LC-3 general-purpose register file with condition-code and branch-enable state.
- Holds R0..R7 and drives them in parallel to the two 8:1 operand-select multiplexers (SR1, SR2) in the datapath.
- Loads from the processor bus under control-FSM strobes.
- Maintains the NZP flags and the BEN bit consumed by the control FSM.

Parameters:
N, 16, data width of each register and of the bus
CC_RESET, 3'b010, NZP value after reset (Z set)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
Bus  input  N  processor bus value to be written
DR  input  3  destination register index
LD_REG  input  1  write Bus into R[DR] at next edge
LD_CC  input  1  update NZP from Bus at next edge
LD_BEN  input  1  update BEN at next edge
IR_NZP  input  3  IR[11:9] branch condition mask
SR1  input  3  operand 1 select
SR2  input  3  operand 2 select
R0..R7  output  N each  registered register contents
SR1_Out  output  N  R[SR1], combinational
SR2_Out  output  N  R[SR2], combinational
NZP  output  3  registered condition codes {N,Z,P}
BEN  output  1  registered branch enable

Behaviour:
- Reset_n low: R0..R7 = 0, NZP = CC_RESET, BEN = 0. The reset is asynchronous: it takes effect immediately, without waiting for a clock edge, and overrides all strobes.
- Reset deassertion mid-instruction: state stays at reset values until the first edge with Reset_n high. No partial write survives.
- Register write: on rising edge with LD_REG=1, R[DR] <= Bus. Exactly one register changes. All other registers hold. Latency is one cycle; the new value is visible on R[DR] and on SRx_Out after the edge.
- No write-through bypass: in the cycle LD_REG is asserted, SR1_Out/SR2_Out return the pre-write value even when SRx == DR.
- Read ports: SR1_Out = R[SR1], SR2_Out = R[SR2], purely combinational from the current register state. SR1 == SR2 is legal and both outputs are equal.
- Condition codes: on edge with LD_CC=1:
  - N <= Bus[N-1]
  - Z <= (Bus == 0)
  - P <= !Bus[N-1] && (Bus != 0)
  - Exactly one bit of NZP is set after any LD_CC.
- BEN: on edge with LD_BEN=1, BEN <= |(IR_NZP & NZP). This uses the registered NZP from before the edge. If LD_CC and LD_BEN are asserted in the same cycle, BEN sees the old flags.
- Simultaneous strobes: LD_REG, LD_CC and LD_BEN are independent. Any combination in one cycle performs all selected updates from the same Bus value.
- DR, SR1, SR2 and IR_NZP values are don't-care when their strobes are low. No X must propagate into state while strobes are low.
- Widths: the zero detect spans all N bits. The sign bit is always Bus[N-1]. No arithmetic is performed.

Decomposition:
- Package lc3_pkg:
  - typedef reg_idx_t (logic [2:0])
  - typedef nzp_t (struct packed {n, z, p})
  - constant CC_RESET_VAL = 3'b010
  - constant NUM_GPR = 8
- Sub-module cc_gen: combinational Bus -> nzp_t, reused later by the PSR logic.
- Read ports: two instances of the team's existing N-bit 8:1 multiplexer (Mux_8to1), selected by SR1/SR2, fed from R0..R7.
- Register array: one always_ff with async reset.

Test Plan:
1. Reset: hold Reset_n=0 mid-clock with LD_REG=1, Bus=16'hFFFF -> R0..R7=0, NZP=3'b010, BEN=0 immediately, with no edge needed.
2. Write/read: LD_REG=1, DR=5, Bus=16'h1234, one edge -> R5=16'h1234, other registers 0. Then SR1=5, SR2=5 -> both outputs 16'h1234.
3. No bypass: R3=16'h0001; in one cycle LD_REG=1, DR=3, Bus=16'h00FF, SR1=3 -> SR1_Out=16'h0001 before the edge, 16'h00FF after.
4. CC boundaries: LD_CC with Bus = 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF -> NZP = 100, 010, 001, 100 respectively.
5. BEN ordering: NZP=010; same cycle LD_CC=1, Bus=16'h8000, LD_BEN=1, IR_NZP=3'b010 -> BEN=1 and NZP=100. Next cycle LD_BEN=1, IR_NZP=3'b010 -> BEN=0.
6. Combined strobes: LD_REG=1, DR=7, LD_CC=1, Bus=16'h0000 -> R7=0, NZP=010, all other registers unchanged.
